// File: rtl/mvm_result_buffer.sv
// Result buffer behind the matrix-vector multiplier: captures one result vector per
// done edge, optionally saturates each word, and replays it on a valid/ready stream.
module mvm_result_buffer #(
  parameter int unsigned MAT_SCALE = 8,
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned SAT       = 1,
  localparam int unsigned IDX_W    = (MAT_SCALE > 1) ? $clog2(MAT_SCALE) : 1,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        done_in,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_WIDTH-1:0] m_data,
  output logic [IDX_W-1:0]            m_index,
  output logic                        m_last,
  output logic                        can_start,
  output logic                        overflow,
  output logic [CNT_W-1:0]            count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = OUT_WIDTH + IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DROP
  } state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_row;
  logic                 r_done_q;
  logic [PTR_W-1:0]     r_rd;
  logic [PTR_W-1:0]     r_wr;
  logic [ENT_W-1:0]     r_mem [DEPTH];

  logic                 w_trigger;
  logic                 w_space_ok;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_row_last;
  logic                 w_busy_nxt;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [CNT_W-1:0]     w_remain;
  logic [PTR_W-1:0]     w_rd_nxt;
  logic [OUT_WIDTH-1:0] w_conv;
  logic [ENT_W-1:0]     w_entry;
  logic [ENT_W-1:0]     w_head;
  logic [IN_WIDTH-OUT_WIDTH:0] w_hi;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Saturate when the bits above the output sign bit are not a pure sign extension
  always_comb begin
    w_hi = data_in[IN_WIDTH-1:OUT_WIDTH-1];
    if ((SAT != 0) && !((&w_hi) || !(|w_hi))) begin
      w_conv = data_in[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else begin
      w_conv = data_in[OUT_WIDTH-1:0];
    end
  end

  assign w_row_last  = (r_row == IDX_W'(MAT_SCALE - 1));
  assign w_trigger   = (r_state == ST_IDLE) && done_in && !r_done_q;
  assign w_space_ok  = (CNT_W'(DEPTH) - count) >= CNT_W'(MAT_SCALE);
  assign w_push      = (r_state == ST_CAPTURE);
  assign w_pop       = m_valid && m_ready;
  assign w_count_nxt = count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_remain    = count - CNT_W'(w_pop);
  assign w_rd_nxt    = w_pop ? ptr_inc(r_rd) : r_rd;
  assign w_entry     = {w_conv, r_row};
  assign w_busy_nxt  = w_trigger || ((r_state != ST_IDLE) && !w_row_last);

  // Next head bypasses the array when the incoming word lands in an otherwise empty FIFO
  assign w_head = (w_remain == '0) ? w_entry : r_mem[w_rd_nxt];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= w_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_row     <= '0;
      r_done_q  <= 1'b0;
      r_rd      <= '0;
      r_wr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_index   <= '0;
      m_last    <= 1'b0;
      can_start <= 1'b1;
    end else begin
      r_done_q <= done_in;

      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_row <= '0;
            if (w_space_ok) begin
              r_state <= ST_CAPTURE;
            end else begin
              r_state  <= ST_DROP;
              overflow <= 1'b1;
            end
          end
        end
        ST_CAPTURE, ST_DROP: begin
          if (w_row_last) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
          end else begin
            r_row <= r_row + IDX_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_row   <= '0;
        end
      endcase

      if (w_push) begin
        r_wr <= ptr_inc(r_wr);
      end
      r_rd    <= w_rd_nxt;
      count   <= w_count_nxt;
      m_valid <= (w_count_nxt != '0);

      // Head registers hold their last word once the FIFO drains
      if (w_count_nxt != '0) begin
        m_data  <= w_head[ENT_W-1:IDX_W];
        m_index <= w_head[IDX_W-1:0];
        m_last  <= (w_head[IDX_W-1:0] == IDX_W'(MAT_SCALE - 1));
      end else begin
        m_last <= 1'b0;
      end

      can_start <= !w_busy_nxt && ((CNT_W'(DEPTH) - w_count_nxt) >= CNT_W'(MAT_SCALE));
    end
  end

endmodule

// File: tb/tb_mvm_result_buffer.sv
// Directed bench for mvm_result_buffer: one saturating instance and one truncating
// instance share stimulus; expectations are hand-computed per scenario.
module tb_mvm_result_buffer;

  logic               clk;
  logic               reset;
  logic               done_in;
  logic signed [31:0] data_in;
  logic               m_ready;

  logic               m_valid,   m_valid0;
  logic signed [15:0] m_data,    m_data0;
  logic [2:0]         m_index,   m_index0;
  logic               m_last,    m_last0;
  logic               can_start, can_start0;
  logic               overflow,  overflow0;
  logic [4:0]         count,     count0;

  int n_pass;
  int n_total;
  int vec [8];
  int exp_s [8];
  int exp_t [8];
  int exp_q [12];
  logic signed [15:0] e16;

  mvm_result_buffer #(.MAT_SCALE(8), .IN_WIDTH(32), .OUT_WIDTH(16), .DEPTH(16), .SAT(1)) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .data_in(data_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .can_start(can_start), .overflow(overflow), .count(count)
  );

  mvm_result_buffer #(.MAT_SCALE(8), .IN_WIDTH(32), .OUT_WIDTH(16), .DEPTH(16), .SAT(0)) dut0 (
    .clk(clk), .reset(reset), .done_in(done_in), .data_in(data_in),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_index(m_index0),
    .m_last(m_last0), .can_start(can_start0), .overflow(overflow0), .count(count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; done_in = 1'b0; data_in = '0; m_ready = 1'b0;
    #3;
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", m_valid); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_total++; if (can_start !== 1'b1) $display("FAIL reset_can_start got %0b exp 1", can_start); else n_pass++;
    n_total++; if (m_index !== 3'd0 || m_last !== 1'b0) $display("FAIL reset_index got %0d/%0b exp 0/0", m_index, m_last); else n_pass++;
    n_total++; if (m_data !== 16'sd0 || overflow !== 1'b0) $display("FAIL reset_data got %0d/%0b exp 0/0", m_data, overflow); else n_pass++;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    vec = '{5, -3, 100, 0, 7, 8, 9, -1};
    m_ready = 1'b1;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    for (int j = 0; j < 8; j++) begin
      data_in = 32'(vec[j]);
      tick();
      e16 = 16'(vec[j]);
      n_total++; if (m_data !== e16 || m_valid !== 1'b1) $display("FAIL basic_data j=%0d got %0d v=%0b exp %0d", j, m_data, m_valid, e16); else n_pass++;
      n_total++; if (m_index !== 3'(j) || m_last !== (j == 7)) $display("FAIL basic_index j=%0d got %0d/%0b exp %0d/%0b", j, m_index, m_last, j, (j == 7)); else n_pass++;
      n_total++; if (count !== 5'd1) $display("FAIL basic_count j=%0d got %0d exp 1", j, count); else n_pass++;
      if (j == 0) begin
        n_total++; if (can_start !== 1'b0) $display("FAIL basic_can_start_busy got %0b exp 0", can_start); else n_pass++;
      end
    end
    data_in = '0;
    tick();
    n_total++; if (count !== 5'd0 || m_valid !== 1'b0 || m_last !== 1'b0) $display("FAIL basic_drained got %0d/%0b/%0b exp 0/0/0", count, m_valid, m_last); else n_pass++;
    n_total++; if (m_data !== -16'sd1 || can_start !== 1'b1) $display("FAIL basic_hold got %0d/%0b exp -1/1", m_data, can_start); else n_pass++;
  endtask

  task automatic test_saturation();
    vec   = '{40000, -40000, 32767, -32768, 0, 1, -1, 65536};
    exp_s = '{32767, -32768, 32767, -32768, 0, 1, -1, 32767};
    exp_t = '{-25536, 25536, 32767, -32768, 0, 1, -1, 0};
    m_ready = 1'b1;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    for (int j = 0; j < 8; j++) begin
      data_in = 32'(vec[j]);
      tick();
      e16 = 16'(exp_s[j]);
      n_total++; if (m_data !== e16) $display("FAIL sat1 j=%0d got %0d exp %0d", j, m_data, e16); else n_pass++;
      e16 = 16'(exp_t[j]);
      n_total++; if (m_data0 !== e16) $display("FAIL sat0 j=%0d got %0d exp %0d", j, m_data0, e16); else n_pass++;
    end
    data_in = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    for (int op = 0; op < 2; op++) begin
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      for (int j = 0; j < 8; j++) begin
        data_in = 32'(op * 10 + j + 1);
        tick();
      end
      data_in = '0;
      if (op == 0) begin
        n_total++; if (count !== 5'd8 || can_start !== 1'b1) $display("FAIL b2b_first got %0d/%0b exp 8/1", count, can_start); else n_pass++;
      end
    end
    n_total++; if (count !== 5'd16 || can_start !== 1'b0) $display("FAIL b2b_full got %0d/%0b exp 16/0", count, can_start); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL b2b_overflow got %0b exp 0", overflow); else n_pass++;
    n_total++; if (m_data !== 16'sd1 || m_index !== 3'd0 || m_valid !== 1'b1) $display("FAIL b2b_head got %0d/%0d/%0b exp 1/0/1", m_data, m_index, m_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    n_total++; if (overflow !== 1'b1 || can_start !== 1'b0) $display("FAIL ovf_set got %0b/%0b exp 1/0", overflow, can_start); else n_pass++;
    for (int j = 0; j < 8; j++) begin
      data_in = 32'(900 + j);
      tick();
    end
    data_in = '0;
    n_total++; if (count !== 5'd16 || m_data !== 16'sd1) $display("FAIL ovf_keep got %0d/%0d exp 16/1", count, m_data); else n_pass++;
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      e16 = 16'((k / 8) * 10 + (k % 8) + 1);
      n_total++; if (m_data !== e16 || m_index !== 3'(k % 8) || m_last !== ((k % 8) == 7)) $display("FAIL ovf_drain k=%0d got %0d/%0d/%0b exp %0d/%0d/%0b", k, m_data, m_index, m_last, e16, k % 8, ((k % 8) == 7)); else n_pass++;
      tick();
    end
    n_total++; if (count !== 5'd0 || m_valid !== 1'b0 || overflow !== 1'b1) $display("FAIL ovf_after got %0d/%0b/%0b exp 0/0/1", count, m_valid, overflow); else n_pass++;
    n_total++; if (m_data !== 16'sd18 || m_last !== 1'b0) $display("FAIL ovf_hold got %0d/%0b exp 18/0", m_data, m_last); else n_pass++;
  endtask

  task automatic test_hold_high();
    reset = 1'b1;
    #2;
    n_total++; if (overflow !== 1'b0) $display("FAIL hold_ovf_clear got %0b exp 0", overflow); else n_pass++;
    reset = 1'b0;
    tick();
    m_ready = 1'b0;
    done_in = 1'b1;
    tick();
    for (int j = 0; j < 20; j++) begin
      data_in = (j < 8) ? 32'(100 + j) : 32'(0);
      tick();
    end
    done_in = 1'b0;
    data_in = '0;
    tick();
    n_total++; if (count !== 5'd8 || m_data !== 16'sd100) $display("FAIL hold_count got %0d/%0d exp 8/100", count, m_data); else n_pass++;
    m_ready = 1'b1;
    repeat (8) tick();
    n_total++; if (count !== 5'd0 || m_data !== 16'sd107) $display("FAIL hold_drain got %0d/%0d exp 0/107", count, m_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    for (int j = 0; j < 3; j++) begin
      data_in = 32'(200 + j);
      tick();
    end
    n_total++; if (count !== 5'd3) $display("FAIL mid_pre got %0d exp 3", count); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++; if (count !== 5'd0 || m_valid !== 1'b0 || can_start !== 1'b1 || m_data !== 16'sd0) $display("FAIL mid_async got %0d/%0b/%0b/%0d exp 0/0/1/0", count, m_valid, can_start, m_data); else n_pass++;
    done_in = 1'b1;
    #2 reset = 1'b0;
    tick();
    done_in = 1'b0;
    m_ready = 1'b1;
    vec = '{-7, 6, -5, 4, -3, 2, -1, 300};
    for (int j = 0; j < 8; j++) begin
      data_in = 32'(vec[j]);
      tick();
      e16 = 16'(vec[j]);
      n_total++; if (m_data !== e16 || m_index !== 3'(j)) $display("FAIL mid_cap j=%0d got %0d/%0d exp %0d/%0d", j, m_data, m_index, e16, j); else n_pass++;
    end
    data_in = '0;
    tick();
    n_total++; if (count !== 5'd0) $display("FAIL mid_end got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_simul_push_pop();
    m_ready = 1'b0;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    for (int j = 0; j < 8; j++) begin
      data_in = 32'(21 + j);
      tick();
    end
    data_in = '0;
    m_ready = 1'b1;
    repeat (4) tick();
    m_ready = 1'b0;
    n_total++; if (count !== 5'd4 || m_data !== 16'sd25) $display("FAIL simul_pre got %0d/%0d exp 4/25", count, m_data); else n_pass++;
    exp_q = '{25, 26, 27, 28, 31, 32, 33, 34, 35, 36, 37, 38};
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    m_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      data_in = 32'(31 + j);
      tick();
      e16 = 16'(exp_q[j + 1]);
      n_total++; if (count !== 5'd4 || m_data !== e16) $display("FAIL simul_cap j=%0d got %0d/%0d exp 4/%0d", j, count, m_data, e16); else n_pass++;
      n_total++; if (m_index !== 3'((j + 1 < 4) ? j + 5 : j - 3)) $display("FAIL simul_idx j=%0d got %0d", j, m_index); else n_pass++;
    end
    data_in = '0;
    for (int k = 9; k < 12; k++) begin
      tick();
      e16 = 16'(exp_q[k]);
      n_total++; if (m_data !== e16) $display("FAIL simul_drain k=%0d got %0d exp %0d", k, m_data, e16); else n_pass++;
    end
    tick();
    n_total++; if (count !== 5'd0 || m_valid !== 1'b0) $display("FAIL simul_end got %0d/%0b exp 0/0", count, m_valid); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_overflow();
    test_hold_high();
    test_reset_mid();
    test_simul_push_pop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mvm_result_buffer.md
Name: mvm_result_buffer

Overview:
- Downstream stage of the matrix-vector multiplier (mvm).
- Captures the MAT_SCALE result words the mvm emits after asserting done, and optionally saturates each to a narrower width.
- Stores words in a FIFO and presents them on a valid/ready stream, so a stalled consumer never loses results. The mvm output itself has no backpressure.
- Exports can_start so the upstream controller issues start only when a whole result vector fits.

Parameters:
- MAT_SCALE, 8, vector length (results per operation).
- IN_WIDTH, 32, width of the mvm data_out (2 x mvm input width).
- OUT_WIDTH, 16, stream word width; legal range OUT_WIDTH <= IN_WIDTH.
- DEPTH, 16, FIFO entries; DEPTH >= MAT_SCALE; any integer, not required to be a power of two.
- SAT, 1, 1 = signed saturation to OUT_WIDTH, 0 = keep low OUT_WIDTH bits.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- done_in, input, 1, mvm done.
- data_in, input, IN_WIDTH (signed), mvm data_out.
- m_valid, output, 1, FIFO head valid.
- m_ready, input, 1, consumer accepts head.
- m_data, output, OUT_WIDTH (signed), head word.
- m_index, output, clog2(MAT_SCALE), row index of head word.
- m_last, output, 1, head is row MAT_SCALE-1.
- can_start, output, 1, free entries >= MAT_SCALE and FSM in IDLE.
- overflow, output, 1, sticky: a result vector was dropped.
- count, output, clog2(DEPTH+1), occupied entries.

Behaviour:
- Reset (async): FSM=IDLE, row counter=0, FIFO empty, done_q=0, overflow=0. Outputs: m_valid=0, count=0, can_start=1, m_index=0, m_last=0, m_data=0.
- mvm timing contract: done_in is high in cycle T; data_in carries y[0..MAT_SCALE-1] in cycles T+1..T+MAT_SCALE, one per cycle, with no gaps.
- Trigger: in IDLE, done_in==1 && done_q==0 (rising edge, where done_q is done_in registered) -> CAPTURE, row=0.
  - done_in held high causes no retrigger.
  - done_in edges during CAPTURE are ignored.
- Space check at trigger: if free = DEPTH-count < MAT_SCALE, go to DROP (same length as CAPTURE) instead of CAPTURE.
  - DROP writes nothing; overflow is set at the trigger edge and stays set until reset.
  - A pop in the trigger cycle does not count toward free space.
- CAPTURE/DROP: each cycle, sample data_in as row `row`, row++. After row MAT_SCALE-1 is sampled, return to IDLE.
  - A new done edge is honoured no earlier than the first IDLE cycle.
- Conversion when SAT=1: word > 2^(OUT_WIDTH-1)-1 -> max; word < -2^(OUT_WIDTH-1) -> min; otherwise the low bits.
  - When SAT=0: low OUT_WIDTH bits.
  - When OUT_WIDTH==IN_WIDTH: pass-through.
- FIFO: first-word-fall-through; entry = {data, index}.
  - m_valid = (count != 0).
  - Pop when m_valid && m_ready.
  - Push and pop in the same cycle -> count unchanged. Push when full cannot occur because of the space check.
  - Read and write pointers wrap modulo DEPTH.
- m_data, m_index and m_last are stable while m_valid && !m_ready.
  - m_last = (m_index == MAT_SCALE-1).
  - When empty, m_data and m_index hold their last values and m_last=0.
- can_start is registered-state based. It is 0 in CAPTURE/DROP, so the upstream controller cannot overlap operations.
- Latency: y[j] sampled at the end of cycle T+1+j is visible on m_data in cycle T+2+j if the FIFO was empty.
- Reset mid-CAPTURE discards partial and stored words. done_in edges are then evaluated fresh (done_q=0, so a done_in already high at reset release triggers).

Test Plan:
- Basic: DEPTH=16, m_ready=1, done pulse then data 5,-3,100,0,7,8,9,-1 -> m_data equals the same sequence in cycles T+2..T+9, m_index 0..7, m_last only on -1, count returns to 0.
- Saturation, SAT=1, OUT_WIDTH=16: inputs 40000, -40000, 32767, -32768 -> 32767, -32768, 32767, -32768.
- Saturation, SAT=0, same inputs: 40000 -> -25536, -40000 -> 25536.
- Backpressure: m_ready=0 through two consecutive operations (DEPTH=16) -> count=16, can_start=0, overflow=0. Then m_ready=1 drains 16 words in order, with m_last after the 8th and 16th.
- Overflow: third done edge while count=16 -> overflow=1, count stays 16, stored data unchanged. Overflow stays 1 after the drain until reset.
- Reset/edge: done_in held high for 20 cycles -> exactly 8 words captured. Reset asserted at row 3 -> count=0, m_valid=0 immediately (async), state IDLE; the next done pulse captures normally.
- Simultaneous push/pop: 4 words pre-stored, m_ready=1 during capture -> count stays at 4 through CAPTURE, then drains; order is preserved.
